// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline MEM stage has priority, the aux master is
// protected by a starvation counter and may lock the memory for bounded bursts.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 16,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_req,
    input  logic        pipe_we,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    output logic        pipe_rvalid,
    output logic [31:0] pipe_rdata,
    output logic        pipe_err,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic        aux_lock,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    output logic        aux_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {ARB, LOCK} state_e;

    localparam logic [7:0] STARVE8   = 8'(STARVE_LIMIT);
    localparam logic [8:0] LOCK_MAX9 = 9'(LOCK_MAX);

    state_e     state_q;
    logic [7:0] starve_q;
    logic [7:0] lock_q;
    logic       rd_pipe_q, rd_aux_q, err_pipe_q, err_aux_q;

    logic pipe_win, aux_win, any_win, win_we, win_bad;
    logic pipe_bad, aux_bad;

    assign pipe_bad = (pipe_addr[1:0] != '0) || (pipe_addr[31:ADDR_W+2] != '0);
    assign aux_bad  = (aux_addr[1:0]  != '0) || (aux_addr[31:ADDR_W+2]  != '0);

    // Grants are gated by rst_n so every output collapses to 0 while reset is held.
    always_comb begin
        aux_win  = rst_n && aux_req &&
                   (state_q == LOCK || !pipe_req || starve_q == STARVE8);
        pipe_win = rst_n && pipe_req && !aux_win;
        any_win  = aux_win || pipe_win;
        win_we   = aux_win ? aux_we  : (pipe_win && pipe_we);
        win_bad  = aux_win ? aux_bad : (pipe_win && pipe_bad);
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (aux_win) begin
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
        end else if (pipe_win) begin
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end
        mem_write  = any_win && win_we && !win_bad;
        mem_read   = any_win && !win_we && !win_bad;
        pipe_stall = rst_n && pipe_req && !pipe_win;
        aux_gnt    = aux_win;
    end

    always_comb begin
        pipe_rvalid = rd_pipe_q || err_pipe_q;
        pipe_err    = err_pipe_q;
        pipe_rdata  = rd_pipe_q ? mem_rdata : '0;
        aux_rvalid  = rd_aux_q || err_aux_q;
        aux_err     = err_aux_q;
        aux_rdata   = rd_aux_q ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe_q  <= 1'b0;
            rd_aux_q   <= 1'b0;
            err_pipe_q <= 1'b0;
            err_aux_q  <= 1'b0;
        end else begin
            rd_pipe_q  <= pipe_win && !pipe_we && !pipe_bad;
            rd_aux_q   <= aux_win && !aux_we && !aux_bad;
            err_pipe_q <= pipe_win && pipe_bad;
            err_aux_q  <= aux_win && aux_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!aux_req || aux_win) begin
            starve_q <= '0;
        end else if (pipe_win && starve_q != '1) begin
            starve_q <= starve_q + 8'd1;
        end
    end

    // lock_q counts aux grants in the current burst; the burst ends on the grant that reaches LOCK_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            lock_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (aux_win && aux_lock && LOCK_MAX > 1) begin
                        state_q <= LOCK;
                        lock_q  <= 8'd1;
                    end
                end
                LOCK: begin
                    if (!aux_lock) begin
                        state_q <= ARB;
                        lock_q  <= '0;
                    end else if (aux_win) begin
                        if ({1'b0, lock_q} + 9'd1 == LOCK_MAX9) begin
                            state_q <= ARB;
                            lock_q  <= '0;
                        end else begin
                            lock_q <= lock_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB;
                    lock_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a cycle-level
// reference model of the arbitration rules and a shadow copy of memory contents.
module tb_dmem_arbiter;

    localparam int STARVE = 4;
    localparam int LMAX   = 16;
    localparam int AW     = 10;
    localparam int WORDS  = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_req, pipe_we, aux_req, aux_we, aux_lock;
    logic [31:0] pipe_addr, pipe_wdata, aux_addr, aux_wdata;
    logic        pipe_stall, pipe_rvalid, pipe_err, aux_gnt, aux_rvalid, aux_err;
    logic [31:0] pipe_rdata, aux_rdata, mem_addr, mem_wdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    int checks = 0;
    int passed = 0;

    // Reference model state
    bit          m_lock;
    int          m_loss, m_burst;
    bit          e_gnt, e_stall, e_mr, e_mw, e_prv, e_perr, e_arv, e_aerr;
    logic [31:0] e_maddr, e_mwd, e_prd, e_ard;
    bit          s_gnt, s_stall, s_mr, s_mw;
    logic [31:0] s_maddr, s_mwd;

    dmem_arbiter #(.STARVE_LIMIT(STARVE), .LOCK_MAX(LMAX), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata), .pipe_err(pipe_err),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .aux_err(aux_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[AW+1:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[AW+1:2]];
    end

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * WORDS));
    endfunction

    task automatic clear_inputs();
        pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0; aux_lock = 0;
    endtask

    task automatic model_reset();
        m_lock = 0; m_loss = 0; m_burst = 0;
        e_prv = 0; e_perr = 0; e_prd = '0; e_arv = 0; e_aerr = 0; e_ard = '0;
    endtask

    // One clock: predict the grant from the current inputs, sample the combinational outputs
    // before the edge, then advance the model across the edge.
    task automatic tick();
        bit aw, pw, we, bad;
        logic [31:0] a, d;
        @(negedge clk);
        aw  = aux_req && (m_lock || !pipe_req || m_loss == STARVE);
        pw  = pipe_req && !aw;
        a   = aw ? aux_addr  : (pw ? pipe_addr  : 32'd0);
        d   = aw ? aux_wdata : (pw ? pipe_wdata : 32'd0);
        we  = aw ? aux_we : (pw && pipe_we);
        bad = (aw || pw) && bad_addr(a);
        e_gnt = aw; e_stall = pipe_req && !pw; e_maddr = a; e_mwd = d;
        e_mw = (aw || pw) && we && !bad;
        e_mr = (aw || pw) && !we && !bad;
        s_gnt = aux_gnt; s_stall = pipe_stall; s_mr = mem_read; s_mw = mem_write;
        s_maddr = mem_addr; s_mwd = mem_wdata;
        @(posedge clk);
        e_prv  = pw && (bad || !we);
        e_perr = pw && bad;
        e_prd  = (pw && e_mr) ? ref_mem[a[AW+1:2]] : 32'd0;
        e_arv  = aw && (bad || !we);
        e_aerr = aw && bad;
        e_ard  = (aw && e_mr) ? ref_mem[a[AW+1:2]] : 32'd0;
        if (e_mw) ref_mem[a[AW+1:2]] = d;
        if (!aux_req || aw) m_loss = 0;
        else if (pw) m_loss++;
        if (!m_lock) begin
            if (aw && aux_lock && LMAX > 1) begin m_lock = 1; m_burst = 1; end
        end else if (!aux_lock) begin
            m_lock = 0;
        end else if (aw) begin
            m_burst++;
            if (m_burst == LMAX) m_lock = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [103:0] outs;
        clear_inputs();
        rst_n = 0;
        model_reset();
        #1;
        outs = {pipe_stall, pipe_rvalid, pipe_err, pipe_rdata, aux_gnt, aux_rvalid, aux_err,
                aux_rdata, mem_write, mem_read, mem_addr[0]};
        checks++;
        if (outs !== '0) $display("FAIL reset_state outputs=%h required=0", outs);
        else passed++;
        @(negedge clk); rst_n = 1;
        pipe_req = 1; pipe_we = 0; pipe_addr = 32'h20;
        tick();
        checks++;
        if (pipe_rvalid !== 1'b1) $display("FAIL reset_preread rvalid=%b required=1", pipe_rvalid);
        else passed++;
        rst_n = 0;
        #1;
        checks++;
        if ({pipe_rvalid, pipe_rdata, pipe_stall, mem_read, mem_addr} !== '0)
            $display("FAIL reset_midread rvalid=%b rdata=%h stall=%b mem_read=%b addr=%h required=0",
                     pipe_rvalid, pipe_rdata, pipe_stall, mem_read, mem_addr);
        else passed++;
        clear_inputs();
        model_reset();
        @(negedge clk); rst_n = 1;
        tick();
        checks++;
        if (pipe_rvalid !== 1'b0 || aux_rvalid !== 1'b0)
            $display("FAIL reset_release prv=%b arv=%b required=0", pipe_rvalid, aux_rvalid);
        else passed++;
    endtask

    task automatic test_pipe_only();
        clear_inputs();
        pipe_req = 1; pipe_we = 1; pipe_addr = 32'h10; pipe_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if ({s_stall, s_mw, s_mr, s_maddr, s_mwd} !== {1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF})
            $display("FAIL pipe_sw stall=%b mw=%b mr=%b addr=%h wd=%h required=0,1,0,10,deadbeef",
                     s_stall, s_mw, s_mr, s_maddr, s_mwd);
        else passed++;
        checks++;
        if (pipe_rvalid !== 1'b0) $display("FAIL pipe_sw_rvalid rvalid=%b required=0", pipe_rvalid);
        else passed++;
        pipe_we = 0; pipe_wdata = '0;
        tick();
        checks++;
        if ({s_stall, s_mr, pipe_rvalid, pipe_err, pipe_rdata} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF})
            $display("FAIL pipe_lw stall=%b mr=%b rvalid=%b err=%b rdata=%h required=0,1,1,0,deadbeef",
                     s_stall, s_mr, pipe_rvalid, pipe_err, pipe_rdata);
        else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_contention();
        clear_inputs();
        pipe_req = 1; pipe_addr = 32'h40; aux_req = 1; aux_addr = 32'h44;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (s_gnt !== (c == 5 || c == 10) || s_stall !== (c == 5 || c == 10))
                $display("FAIL contention_c%0d gnt=%b stall=%b required=%b", c, s_gnt, s_stall,
                         (c == 5 || c == 10));
            else passed++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock();
        int grants = 0;
        clear_inputs();
        pipe_req = 1; pipe_addr = 32'h80; aux_req = 1; aux_addr = 32'h84; aux_lock = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (s_gnt) grants++;
        end
        checks++;
        if (grants != 16) $display("FAIL lock_grants count=%0d required=16", grants);
        else passed++;
        tick();
        checks++;
        if (s_gnt !== 1'b0 || s_stall !== 1'b0)
            $display("FAIL lock_release gnt=%b stall=%b required=0,0", s_gnt, s_stall);
        else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_errors();
        clear_inputs();
        aux_req = 1; aux_addr = 32'h1002;
        tick();
        checks++;
        if ({s_gnt, s_mr, s_mw, aux_rvalid, aux_err, aux_rdata} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0})
            $display("FAIL aux_err gnt=%b mr=%b mw=%b rvalid=%b err=%b rdata=%h required=1,0,0,1,1,0",
                     s_gnt, s_mr, s_mw, aux_rvalid, aux_err, aux_rdata);
        else passed++;
        clear_inputs();
        pipe_req = 1; pipe_addr = 32'h1000;
        tick();
        checks++;
        if ({s_stall, s_mr, s_mw, pipe_rvalid, pipe_err, pipe_rdata, aux_rvalid} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0})
            $display("FAIL pipe_err stall=%b mr=%b mw=%b rvalid=%b err=%b rdata=%h arv=%b required=0,0,0,1,1,0,0",
                     s_stall, s_mr, s_mw, pipe_rvalid, pipe_err, pipe_rdata, aux_rvalid);
        else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_routing();
        logic [31:0] pat;
        clear_inputs();
        for (int k = 0; k < 6; k++) begin
            pipe_req = 1; pipe_we = 1; pipe_addr = 32'h200 + 32'(4 * k);
            pipe_wdata = 32'hA5A50000 + 32'(k * 32'h111);
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            pat = 32'hA5A50000 + 32'(k * 32'h111);
            if (k % 2 == 0) begin pipe_req = 1; pipe_addr = 32'h200 + 32'(4 * k); end
            else begin aux_req = 1; aux_addr = 32'h200 + 32'(4 * k); end
            tick();
            checks++;
            if (k % 2 == 0 && {pipe_rvalid, pipe_rdata, aux_rvalid, aux_rdata} !== {1'b1, pat, 1'b0, 32'd0})
                $display("FAIL route_pipe%0d prv=%b prd=%h arv=%b ard=%h required=1,%h,0,0",
                         k, pipe_rvalid, pipe_rdata, aux_rvalid, aux_rdata, pat);
            else if (k % 2 == 1 && {aux_rvalid, aux_rdata, pipe_rvalid, pipe_rdata} !== {1'b1, pat, 1'b0, 32'd0})
                $display("FAIL route_aux%0d arv=%b ard=%h prv=%b prd=%h required=1,%h,0,0",
                         k, aux_rvalid, aux_rdata, pipe_rvalid, pipe_rdata, pat);
            else passed++;
        end
        clear_inputs();
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return 32'($urandom_range(0, 63) * 4);
    endfunction

    task automatic test_random();
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            pipe_req = ($urandom_range(0, 2) != 0);
            pipe_we = $urandom_range(0, 1);
            pipe_addr = rand_addr();
            pipe_wdata = $urandom;
            if (!(aux_req && !e_gnt)) begin
                aux_req = ($urandom_range(0, 2) != 0);
                aux_we = $urandom_range(0, 1);
                aux_addr = rand_addr();
                aux_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) aux_lock = ~aux_lock;
            tick();
            checks++;
            if ({s_gnt, s_stall, s_mr, s_mw, s_maddr, s_mwd} !== {e_gnt, e_stall, e_mr, e_mw, e_maddr, e_mwd})
                $display("FAIL rand_issue_c%0d gnt/stall/mr/mw=%b%b%b%b addr=%h wd=%h required=%b%b%b%b %h %h",
                         c, s_gnt, s_stall, s_mr, s_mw, s_maddr, s_mwd,
                         e_gnt, e_stall, e_mr, e_mw, e_maddr, e_mwd);
            else passed++;
            checks++;
            if ({pipe_rvalid, pipe_err, pipe_rdata, aux_rvalid, aux_err, aux_rdata} !==
                {e_prv, e_perr, e_prd, e_arv, e_aerr, e_ard})
                $display("FAIL rand_return_c%0d p=%b%b %h a=%b%b %h required p=%b%b %h a=%b%b %h",
                         c, pipe_rvalid, pipe_err, pipe_rdata, aux_rvalid, aux_err, aux_rdata,
                         e_prv, e_perr, e_prd, e_arv, e_aerr, e_ard);
            else passed++;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_pipe_only();
        test_contention();
        test_lock();
        test_errors();
        test_routing();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
